// File: rtl/simple_pipe_pkg.sv
// ----------------------------------------------------------------------------
// simple_pipe_pkg
// Shared definitions for the 4 x 8-bit register simple pipeline controller:
// opcode encodings, instruction field positions, the packed pipe-stage record
// and a small decode helper.
// ----------------------------------------------------------------------------
package simple_pipe_pkg;

    // Datapath width carried by the pipe-stage record.
    localparam int PIPE_DATA_W = 8;

    // Opcode encodings (inst[7:6]).
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    // Instruction field positions: [7:6] op, [5:4] rs1, [3:2] rs2, [1:0] rd.
    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RS1_HI = 5;
    localparam int RS1_LO = 4;
    localparam int RS2_HI = 3;
    localparam int RS2_LO = 2;
    localparam int RD_HI  = 1;
    localparam int RD_LO  = 0;

    // One pipeline stage worth of state.
    typedef struct packed {
        logic                   valid;
        logic [1:0]             op;
        logic [1:0]             rs1;
        logic [1:0]             rs2;
        logic [1:0]             rd;
        logic [PIPE_DATA_W-1:0] result;
    } pipe_stage_t;

    // True for every op that writes its destination register.
    function automatic logic op_writes(input logic [1:0] op);
        return (op != OP_NOP);
    endfunction

endpackage

// File: rtl/simple_pipe_alu.sv
// ----------------------------------------------------------------------------
// simple_pipe_alu
// Combinational ALU used in the EX stage.
// Ports:
//   op     in  2       opcode (NOP/ADD/SUB/NAND)
//   a, b   in  DATA_W  operands (rs1, rs2)
//   result out DATA_W  ADD/SUB wrap modulo 2^DATA_W; NOP yields zero
// ----------------------------------------------------------------------------
module simple_pipe_alu
    import simple_pipe_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    // Operation select; carries and borrows fall off the top.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_NAND: result = ~(a & b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/simple_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// simple_pipe_ctrl
// Issue/sequencing controller for the simple pipeline. Instructions are
// accepted over inst_valid/inst_ready, computed in EX and retired from WB,
// which owns the single write port of r0..r3.
//
// Build option: FORWARD_EN
//   undefined - a read-after-write dependency on the instruction in WB holds
//               EX for one cycle and drops a bubble into WB (counted in
//               stall_cnt).
//   defined   - the WB result is forwarded into EX, issue never stalls and
//               stall_cnt stays zero.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   inst_valid/inst_ready/inst instruction handshake ([7:6] op, [5:4] rs1,
//                              [3:2] rs2, [1:0] rd)
//   r0_out..r3_out             architectural register values
//   retire_valid/retire_inst   one-cycle pulse and instruction leaving WB
//   retire_cnt                 retired instruction count (wraps)
//   stall_cnt                  hazard stall cycle count (saturates)
// ----------------------------------------------------------------------------
module simple_pipe_ctrl
    import simple_pipe_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter int                CNT_W   = 16,
    parameter logic [DATA_W-1:0] RST_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [7:0]        inst,
    output logic [DATA_W-1:0] r0_out,
    output logic [DATA_W-1:0] r1_out,
    output logic [DATA_W-1:0] r2_out,
    output logic [DATA_W-1:0] r3_out,
    output logic              retire_valid,
    output logic [7:0]        retire_inst,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              ex_valid_r;
    logic [7:0]        ex_inst_r;
    pipe_stage_t       wb_r;
    logic [DATA_W-1:0] rf_r [0:3];
    logic [CNT_W-1:0]  retire_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic [1:0]        ex_op_s;
    logic [1:0]        ex_rs1_s;
    logic [1:0]        ex_rs2_s;
    logic [1:0]        ex_rd_s;
    logic [DATA_W-1:0] opa_s;
    logic [DATA_W-1:0] opb_s;
    logic [DATA_W-1:0] alu_result_s;
    logic              wb_writes_s;
    logic              hazard_s;
    logic              accept_s;

    assign ex_op_s  = ex_inst_r[OP_HI:OP_LO];
    assign ex_rs1_s = ex_inst_r[RS1_HI:RS1_LO];
    assign ex_rs2_s = ex_inst_r[RS2_HI:RS2_LO];
    assign ex_rd_s  = ex_inst_r[RD_HI:RD_LO];

    // A NOP (or bubble) in WB never produces a value anyone depends on.
    assign wb_writes_s = wb_r.valid && op_writes(wb_r.op);

`ifdef FORWARD_EN
    // Operand fetch with bypass of the WB result; dependencies never stall.
    always_comb begin
        hazard_s = 1'b0;
        if (wb_writes_s && (wb_r.rd == ex_rs1_s)) begin
            opa_s = wb_r.result;
        end else begin
            opa_s = rf_r[ex_rs1_s];
        end
        if (wb_writes_s && (wb_r.rd == ex_rs2_s)) begin
            opb_s = wb_r.result;
        end else begin
            opb_s = rf_r[ex_rs2_s];
        end
    end
`else
    // Operand fetch from the register file; a pending WB write to a source
    // register is a hazard that holds EX until the write has landed.
    always_comb begin
        opa_s    = rf_r[ex_rs1_s];
        opb_s    = rf_r[ex_rs2_s];
        hazard_s = ex_valid_r && wb_writes_s &&
                   ((wb_r.rd == ex_rs1_s) || (wb_r.rd == ex_rs2_s));
    end
`endif

    assign inst_ready = rst_n && (!ex_valid_r || !hazard_s);
    assign accept_s   = inst_valid && inst_ready;

    simple_pipe_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (ex_op_s),
        .a      (opa_s),
        .b      (opb_s),
        .result (alu_result_s)
    );

    // EX stage register: loads on accept, holds while a hazard is pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_r <= 1'b0;
            ex_inst_r  <= 8'h00;
        end else if (!hazard_s) begin
            ex_valid_r <= accept_s;
            if (accept_s) begin
                ex_inst_r <= inst;
            end else begin
                ex_inst_r <= ex_inst_r;
            end
        end else begin
            ex_valid_r <= ex_valid_r;
            ex_inst_r  <= ex_inst_r;
        end
    end

    // WB stage register: takes the EX result, or an all-zero bubble so that
    // retire_inst reads zero whenever nothing retires.
    always_ff @(posedge clk) begin
        if (!rst_n || hazard_s || !ex_valid_r) begin
            wb_r <= '0;
        end else begin
            wb_r.valid  <= 1'b1;
            wb_r.op     <= ex_op_s;
            wb_r.rs1    <= ex_rs1_s;
            wb_r.rs2    <= ex_rs2_s;
            wb_r.rd     <= ex_rd_s;
            wb_r.result <= alu_result_s;
        end
    end

    // Architectural register file, written only from WB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rf_r[i] <= RST_VAL;
            end
        end else if (wb_writes_s) begin
            rf_r[wb_r.rd] <= wb_r.result;
        end else begin
            rf_r <= rf_r;
        end
    end

    // Retire counter (wraps, NOPs included) and stall counter (saturates).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_cnt_r <= '0;
            stall_cnt_r  <= '0;
        end else begin
            if (wb_r.valid) begin
                retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                retire_cnt_r <= retire_cnt_r;
            end
            if (hazard_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign r0_out       = rf_r[0];
    assign r1_out       = rf_r[1];
    assign r2_out       = rf_r[2];
    assign r3_out       = rf_r[3];
    assign retire_valid = wb_r.valid;
    assign retire_inst  = {wb_r.op, wb_r.rs1, wb_r.rs2, wb_r.rd};
    assign retire_cnt   = retire_cnt_r;
    assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_simple_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_simple_pipe_ctrl
// Self-checking bench for simple_pipe_ctrl. A table of instructions with
// hand-computed destination values is issued one at a time; a scoreboard
// queue checks every retire (instruction and latency); hand-written
// sequences cover reset, the dependent pair and reset with work in flight.
// ----------------------------------------------------------------------------
module tb_simple_pipe_ctrl;

`ifdef FORWARD_EN
    localparam int EXP_STALL = 0;
`else
    localparam int EXP_STALL = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid = 1'b0;
    logic [7:0]  inst = 8'h00;
    logic        inst_ready;
    logic [7:0]  r0_out, r1_out, r2_out, r3_out;
    logic        retire_valid;
    logic [7:0]  retire_inst;
    logic [15:0] retire_cnt;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] inst;
        int         acc_cyc;
        bit         chk_lat;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [7:0] inst;
        logic [1:0] chk_reg;
        logic [7:0] exp_val;
    } vec_t;
    vec_t vecs[17];

    logic [7:0] m_rf [4];

    simple_pipe_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .r0_out       (r0_out),
        .r1_out       (r1_out),
        .r2_out       (r2_out),
        .r3_out       (r3_out),
        .retire_valid (retire_valid),
        .retire_inst  (retire_inst),
        .retire_cnt   (retire_cnt),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] get_reg(input logic [1:0] i);
        case (i)
            2'd0:    return r0_out;
            2'd1:    return r1_out;
            2'd2:    return r2_out;
            default: return r3_out;
        endcase
    endfunction

    // Sequential ISA model: each instruction sees all earlier ones.
    task automatic model_exec(input logic [7:0] i);
        logic [7:0] a, b;
        a = m_rf[i[5:4]];
        b = m_rf[i[3:2]];
        case (i[7:6])
            2'b01:   m_rf[i[1:0]] = a + b;
            2'b10:   m_rf[i[1:0]] = a - b;
            2'b11:   m_rf[i[1:0]] = ~(a & b);
            default: ;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    endtask

    // Offer one instruction at a negedge, wait (bounded) for ready, and
    // return at the negedge after the accepting posedge with valid dropped.
    task automatic issue(input logic [7:0] i, input bit chk_lat);
        int  n = 0;
        sb_t e;
        inst_valid = 1'b1;
        inst       = i;
        while (!inst_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!inst_ready) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: inst %0h not accepted, ready=%0b expected 1", i, inst_ready);
            inst_valid = 1'b0;
            return;
        end
        e.inst    = i;
        e.acc_cyc = cyc;
        e.chk_lat = chk_lat;
        sb_q.push_back(e);
        model_exec(i);
        @(negedge clk);
        inst_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_regs_zero(input string tag);
        for (int r = 0; r < 4; r++)
            check($sformatf("%s_r%0d", tag, r), get_reg(r[1:0]), 32'h0);
    endtask

    // Retire monitor: pops the scoreboard on every retire pulse.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n && retire_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL retire_unexpected: got inst %0h, expected no retire", retire_inst);
            end else begin
                e = sb_q.pop_front();
                check("retire_inst", retire_inst, e.inst);
                if (e.chk_lat)
                    check("retire_latency", cyc - e.acc_cyc, 32'd2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_low;

        // inst, register to inspect, its expected value after retiring
        vecs[0]  = '{8'hC3, 2'd3, 8'hFF};  // r3 = ~(r0&r0)
        vecs[1]  = '{8'h8D, 2'd1, 8'h01};  // r1 = r0 - r3 (wrap)
        vecs[2]  = '{8'h55, 2'd1, 8'h02};  // r1 = r1 + r1
        vecs[3]  = '{8'h56, 2'd2, 8'h04};  // r2 = r1 + r1
        vecs[4]  = '{8'h9D, 2'd1, 8'h03};  // r1 = r1 - r3
        vecs[5]  = '{8'hAE, 2'd2, 8'h05};  // r2 = r2 - r3
        vecs[6]  = '{8'h58, 2'd0, 8'h08};  // r0 = r1 + r2 = 3 + 5
        vecs[7]  = '{8'h42, 2'd2, 8'h10};  // r2 = r0 + r0
        vecs[8]  = '{8'hFD, 2'd1, 8'h00};  // r1 = ~(r3&r3)
        vecs[9]  = '{8'h99, 2'd1, 8'hF0};  // r1 = r1 - r2
        vecs[10] = '{8'h6A, 2'd2, 8'h20};  // r2 = r2 + r2
        vecs[11] = '{8'h5B, 2'd3, 8'h10};  // r3 = F0 + 20, carry dropped
        vecs[12] = '{8'hA4, 2'd0, 8'h30};  // r0 = 20 - F0, wraps
        vecs[13] = '{8'hA8, 2'd0, 8'h00};  // r0 = r2 - r2
        vecs[14] = '{8'hC1, 2'd1, 8'hFF};  // r1 = ~(r0&r0)
        vecs[15] = '{8'h76, 2'd2, 8'h0F};  // r2 = r3 + r1
        vecs[16] = '{8'hDB, 2'd3, 8'hF0};  // r3 = ~(FF & 0F)

        // Reset held with an instruction offered.
        model_reset();
        rst_n      = 1'b0;
        inst_valid = 1'b1;
        inst       = 8'hC3;
        repeat (3) begin
            @(negedge clk);
            check("rst_inst_ready", inst_ready, 32'h0);
        end
        check_regs_zero("rst");
        check("rst_retire_cnt", retire_cnt, 32'h0);
        check("rst_retire_valid", retire_valid, 32'h0);
        check("rst_retire_inst", retire_inst, 32'h0);
        rst_n      = 1'b1;
        inst_valid = 1'b0;
        @(negedge clk);
        check("idle_inst_ready", inst_ready, 32'h1);

        // Table: each instruction issued alone and drained.
        for (int k = 0; k < 17; k++) begin
            issue(vecs[k].inst, 1'b1);
            drain(4);
            check($sformatf("vec%0d_r%0d", k, vecs[k].chk_reg),
                  get_reg(vecs[k].chk_reg), vecs[k].exp_val);
        end
        check("tbl_retire_cnt", retire_cnt, 32'd17);
        check("tbl_stall_cnt", stall_cnt, 32'd0);
        for (int r = 0; r < 4; r++)
            check($sformatf("tbl_model_r%0d", r), get_reg(r[1:0]), m_rf[r]);

        // Dependent back-to-back pair: r0 = r1+r1, then r2 = r0+r1.
        issue(8'h54, 1'b0);
        issue(8'h46, 1'b0);
        ready_low = 0;
        for (int k = 0; k < 6; k++) begin
            if (!inst_ready) ready_low++;
            @(negedge clk);
        end
        check("pair_ready_low_cycles", ready_low, EXP_STALL);
        check("pair_stall_cnt", stall_cnt, EXP_STALL);
        check("pair_r0", r0_out, 32'hFE);
        check("pair_r2", r2_out, 32'hFD);
        check("pair_retire_cnt", retire_cnt, 32'd19);

        // Reset with one instruction in WB and one in EX.
        issue(8'hC3, 1'b0);
        issue(8'h55, 1'b0);
        check("mid_wb_busy", retire_valid, 32'h1);
        rst_n = 1'b0;
        sb_q.delete();
        model_reset();
        @(negedge clk);
        check("mid_rst_retire_valid", retire_valid, 32'h0);
        @(negedge clk);
        check("mid_rst_retire_valid2", retire_valid, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_regs_zero("mid");
        check("mid_retire_cnt", retire_cnt, 32'h0);
        check("mid_stall_cnt", stall_cnt, 32'h0);
        check("mid_retire_valid", retire_valid, 32'h0);

        // Ten back-to-back NOPs.
        for (int k = 0; k < 10; k++) issue(8'h00, 1'b1);
        drain(4);
        check("nop_retire_cnt", retire_cnt, 32'd10);
        check_regs_zero("nop");
        check("sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
